serial_subtractor_16bit: RTL
============================

# serial_subtractor_16bit

Multi-cycle 16-bit two's-complement subtractor computing `diff = in1 - in2 - b_in` one bit per clock, using a single full-adder cell fed with the inverted subtrahend. It is the subtraction counterpart to the team's 16-bit ripple-carry adder. It trades 16 cycles of latency for one adder cell, and it sits beside the adder in the arithmetic datapath. A start/busy/done handshake frames each operation, and the result registers hold their value until the next operation completes.

## Interface
- No parameters; width fixed at 16.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: operation request, sampled on rising edge.
- `in1` input 16: minuend, captured on accepted start.
- `in2` input 16: subtrahend, captured on accepted start.
- `b_in` input 1: borrow in, captured on accepted start.
- `diff` output 16: result, updated only at completion.
- `b_out` output 1: borrow out; 1 iff `in1 < in2 + b_in` (unsigned).
- `ovf` output 1: signed overflow flag.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle completion pulse.

## Operation
- FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - `start=1` at an edge is accepted. The block latches `a=in1` and `b=~in2`, sets the internal `carry=~b_in` and `cnt=0`, then moves to RUN.
  - `start=0` keeps the FSM in IDLE.
- RUN, at each edge:
  - Compute `s = a[cnt]^b[cnt]^carry`.
  - Compute `carry = maj(a[cnt], b[cnt], carry)`.
  - Shift `s` into the MSB of the internal shift register `sr` (right shift).
  - Increment `cnt`.
  - On the edge that processes `cnt=15`, go to DONE. On that same edge, load `diff <= final sr` and `b_out <= ~carry_out`, and set `ovf <= (a[15]!=in2_latched[15]) && (s15!=a[15])`.
- DONE: lasts exactly one cycle, then returns unconditionally to IDLE. `start` is ignored in DONE.
- `start` is ignored in RUN and DONE. No queuing; the request is dropped.
- Input changes after acceptance have no effect; operands are latched.
- Between completions, `diff`, `b_out` and `ovf` are held stable, including throughout a subsequent RUN.
- `cnt` is 4 bits, and the transition out of RUN is decoded at `cnt==15`. The counter must not wrap into a 17th bit step.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `diff=16'h0000`, `b_out=0`, `ovf=0`. Internal `cnt`, `sr` and `carry` are cleared.
- `busy` and `done` are registered, decoded from state. `busy=1` in RUN only; `done=1` in DONE only.
- Latency (start accepted at edge E0):
  - `busy` rises after E0.
  - Bits 0..15 are processed at edges E1..E16.
  - `diff`, `b_out` and `ovf` are valid, and `done=1`, after E16.
  - `done` falls after E17.
  - The earliest next accept is E18 (throughput: one operation per 18 cycles).
- Reset asserted mid-RUN aborts immediately, asynchronously, to reset values. No `done` pulse follows. The previous `diff` is lost (cleared to 0).
- Reset deasserted while `start=1`: start is accepted at the first edge after deassertion.

## Test plan
- Basic subtraction: `in1=0x0005`, `in2=0x0003`, `b_in=0`, start at E0.
  - `done` must be high exactly at cycle E16..E17.
  - Required result: `diff=0x0002`, `b_out=0`, `ovf=0`.
  - `busy` must be high for exactly 16 cycles.
- Unsigned underflow: `0x0000 - 0x0001` must give `diff=0xFFFF`, `b_out=1`, `ovf=0`.
- Signed overflow, both directions:
  - `0x8000 - 0x0001` must give `diff=0x7FFF`, `b_out=0`, `ovf=1`.
  - `0x7FFF - 0xFFFF` must give `diff=0x8000`, `b_out=1`, `ovf=1`.
- Borrow in: `0x0010 - 0x0010` with `b_in=1` must give `diff=0xFFFF`, `b_out=1`, `ovf=0`.
- Ignored requests:
  - Pulse `start` with new operands at E5 (RUN) and at E16 (DONE). The original result is produced unchanged and no second operation begins.
  - Change `in1`/`in2` at E3; the result must be unaffected.
- Reset mid-operation:
  1. Complete `0x1234 - 0x0034`; expect `diff=0x1200`.
  2. Start `0xFFFF - 0x0001`, then assert `rst` at E8. Outputs must go to reset values immediately, with no `done` pulse.
  3. After release, a new `0x0003 - 0x0005` must give `0xFFFE`, `b_out=1` with the normal 16-cycle latency.

Source files
------------

// File: rtl/serial_subtractor_16bit.sv
// serial_subtractor_16bit
//
// Bit-serial 16-bit two's-complement subtractor: diff = in1 - in2 - b_in.
// A single full-adder cell adds the minuend to the inverted subtrahend, one
// bit per clock from LSB to MSB, with the carry seeded by ~b_in. Each
// operation is framed by a start/busy/done handshake and takes 16 RUN cycles
// followed by one DONE cycle.
//
// Ports:
//   i_clk    - clock, all state updates on the rising edge
//   i_rst    - asynchronous active-high reset
//   i_start  - operation request, accepted only in IDLE
//   i_in1    - minuend, latched on accept
//   i_in2    - subtrahend, latched on accept
//   i_b_in   - borrow in, latched on accept
//   o_diff   - result, updated only at completion
//   o_b_out  - borrow out (in1 < in2 + b_in, unsigned)
//   o_ovf    - signed overflow
//   o_busy   - high while bits are being processed (RUN)
//   o_done   - one-cycle completion pulse (DONE)

module serial_subtractor_16bit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_in1,
    input  logic [15:0] i_in2,
    input  logic        i_b_in,
    output logic [15:0] o_diff,
    output logic        o_b_out,
    output logic        o_ovf,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_a;       // latched minuend
    logic [15:0] r_b;       // latched inverted subtrahend
    logic        r_carry;   // full-adder carry, seeded with ~b_in
    logic [3:0]  r_cnt;     // bit index currently being processed
    // Only 15 partial-sum bits are stored: the 16th sum bit goes straight
    // into o_diff on the completing edge together with these.
    logic [14:0] r_sr;

    logic w_a_bit;
    logic w_b_bit;
    logic w_sum;
    logic w_cout;
    logic w_last;

    assign w_a_bit = r_a[r_cnt];
    assign w_b_bit = r_b[r_cnt];
    assign w_sum   = w_a_bit ^ w_b_bit ^ r_carry;
    assign w_cout  = (w_a_bit & w_b_bit) | (w_a_bit & r_carry) | (w_b_bit & r_carry);
    assign w_last  = (r_cnt == 4'd15);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_carry <= 1'b0;
            r_cnt   <= 4'd0;
            r_sr    <= 15'h0000;
            o_diff  <= 16'h0000;
            o_b_out <= 1'b0;
            o_ovf   <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        r_a     <= i_in1;
                        r_b     <= ~i_in2;
                        r_carry <= ~i_b_in;
                        r_cnt   <= 4'd0;
                        o_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sr    <= {w_sum, r_sr[14:1]};
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 4'd1;
                    if (w_last) begin
                        o_diff  <= {w_sum, r_sr};
                        // Carry out of a + ~b + ~b_in is the inverse of borrow.
                        o_b_out <= ~w_cout;
                        // Operand signs differ (true subtrahend sign is ~r_b[15])
                        // and the result sign departs from the minuend sign.
                        o_ovf   <= (r_a[15] != ~r_b[15]) && (w_sum != r_a[15]);
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
